// File: rtl/vga_regs_pkg.sv
// ----------------------------------------------------------------------------
// vga_regs_pkg
// Shared definitions for the VGA register bank:
//   - bus address map (value, four player scores, COMMIT, STATUS, FRAME)
//   - STATUS register bit positions
//   - commit FSM state type (IDLE = nothing pending, ARMED = copy on next vsync)
// ----------------------------------------------------------------------------
package vga_regs_pkg;

    localparam logic [2:0] ADDR_VALUE  = 3'd0;
    localparam logic [2:0] ADDR_P1     = 3'd1;
    localparam logic [2:0] ADDR_P2     = 3'd2;
    localparam logic [2:0] ADDR_P3     = 3'd3;
    localparam logic [2:0] ADDR_P4     = 3'd4;
    localparam logic [2:0] ADDR_COMMIT = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;
    localparam logic [2:0] ADDR_FRAME  = 3'd7;

    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_VSYNC_BIT   = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

endpackage : vga_regs_pkg

// File: rtl/vsync_edge.sv
// ----------------------------------------------------------------------------
// vsync_edge
// Normalises vsync polarity and detects the start of vertical sync.
//   clk, rst    : system clock, asynchronous active-high reset
//   vsync       : raw vsync from the VGA top
//   active      : vsync asserted (polarity-corrected, combinational)
//   start_pulse : one-cycle registered pulse, high the cycle after vsync
//                 becomes active
// ----------------------------------------------------------------------------
module vsync_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic active,
    output logic start_pulse
);

    logic vs_prev_q;
    logic start_q;

    assign active = ACTIVE_LOW ? ~vsync : vsync;

    // vs_prev is kept in "active" polarity, so reset value 0 means inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            vs_prev_q <= active;
            start_q   <= active & ~vs_prev_q;
        end
    end

    assign start_pulse = start_q;

endmodule : vsync_edge

// File: rtl/vga_reg_bank.sv
// ----------------------------------------------------------------------------
// vga_reg_bank
// CPU-visible register bank feeding the VGA display. Writes land in staging
// registers; a COMMIT arms a copy of all staging registers to the live outputs
// at the next start of vertical sync, so the display never tears.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   we, re, addr, wdata : bus write/read strobes, address, write data
//   rdata, rvalid       : registered read data, valid one cycle after re
//   vsync               : vsync from the VGA top
//   value, p1..p4       : live display values
//   commit_done         : one-cycle pulse in the cycle the live copy is taken
//
// Optional feature: define VGA_FRAME_CNT_EN to add a frame counter at
// address 7 (counts vsync starts, cleared by any write to address 7).
// ----------------------------------------------------------------------------
module vga_reg_bank
    import vga_regs_pkg::*;
#(
    parameter int DATA_W           = 16,
    parameter int VAL_W            = 8,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              vsync,
    output logic [VAL_W-1:0]  value,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic              commit_done
);

    logic vs_active_s;
    logic vs_start_s;

    vsync_edge #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW != 0)
    ) u_vsync_edge (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .active      (vs_active_s),
        .start_pulse (vs_start_s)
    );

    state_e            state_q, state_d;
    logic [VAL_W-1:0]  val_stg_q, val_stg_d, val_live_q, val_live_d;
    logic [DATA_W-1:0] p_stg_q  [4];
    logic [DATA_W-1:0] p_stg_d  [4];
    logic [DATA_W-1:0] p_live_q [4];
    logic [DATA_W-1:0] p_live_d [4];
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_mux_s;
    logic              rvalid_q, rvalid_d;
    logic              commit_wr_s;
    logic              copy_s;

    assign commit_wr_s = we && (addr == ADDR_COMMIT);
    // Both terms are flop outputs, so the pulse is clean for one full cycle.
    assign copy_s      = (state_q == ARMED) && vs_start_s;

    // Commit FSM: a COMMIT write always (re)arms; a vsync start only disarms
    // when it actually performs the copy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (commit_wr_s) begin
                    state_d = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (vs_start_s && !commit_wr_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Staging next-state: bus writes to addresses 0..4.
    always_comb begin
        val_stg_d = val_stg_q;
        p_stg_d   = p_stg_q;
        if (we) begin
            case (addr)
                ADDR_VALUE: val_stg_d  = wdata[VAL_W-1:0];
                ADDR_P1:    p_stg_d[0] = wdata;
                ADDR_P2:    p_stg_d[1] = wdata;
                ADDR_P3:    p_stg_d[2] = wdata;
                ADDR_P4:    p_stg_d[3] = wdata;
                default:    val_stg_d  = val_stg_q;
            endcase
        end else begin
            val_stg_d = val_stg_q;
        end
    end

    // Live next-state: copy of the pre-write staging contents on commit.
    always_comb begin
        val_live_d = val_live_q;
        p_live_d   = p_live_q;
        if (copy_s) begin
            val_live_d = val_stg_q;
            p_live_d   = p_stg_q;
        end else begin
            val_live_d = val_live_q;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [DATA_W-1:0] frame_q, frame_d;

    // Frame counter: a write to FRAME clears it even on a vsync start.
    always_comb begin
        frame_d = frame_q;
        if (we && (addr == ADDR_FRAME)) begin
            frame_d = '0;
        end else if (vs_start_s) begin
            frame_d = frame_q + DATA_W'(1'b1);
        end else begin
            frame_d = frame_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end
`endif

    // Read mux over current (pre-write) register contents.
    always_comb begin
        rd_mux_s = '0;
        case (addr)
            ADDR_VALUE:  rd_mux_s[VAL_W-1:0] = val_stg_q;
            ADDR_P1:     rd_mux_s = p_stg_q[0];
            ADDR_P2:     rd_mux_s = p_stg_q[1];
            ADDR_P3:     rd_mux_s = p_stg_q[2];
            ADDR_P4:     rd_mux_s = p_stg_q[3];
            ADDR_STATUS: begin
                rd_mux_s[STATUS_PENDING_BIT] = (state_q == ARMED);
                rd_mux_s[STATUS_VSYNC_BIT]   = vs_active_s;
            end
`ifdef VGA_FRAME_CNT_EN
            ADDR_FRAME:  rd_mux_s = frame_q;
`endif
            default:     rd_mux_s = '0;
        endcase
    end

    // Read response: rdata holds when no read is accepted.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re;
        if (re) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // All state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            val_stg_q  <= '0;
            val_live_q <= '0;
            p_stg_q    <= '{default: '0};
            p_live_q   <= '{default: '0};
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            val_stg_q  <= val_stg_d;
            val_live_q <= val_live_d;
            p_stg_q    <= p_stg_d;
            p_live_q   <= p_live_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign value       = val_live_q;
    assign p1          = p_live_q[0];
    assign p2          = p_live_q[1];
    assign p3          = p_live_q[2];
    assign p4          = p_live_q[3];
    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign commit_done = copy_s;

endmodule : vga_reg_bank

// File: tb/tb_vga_reg_bank.sv
// ----------------------------------------------------------------------------
// tb_vga_reg_bank
// Directed stimulus for vga_reg_bank with a register-map level reference model
// checked every cycle, plus hand-computed expectations for key scenarios.
// ----------------------------------------------------------------------------
module tb_vga_reg_bank;

    logic        clk = 1'b0;
    logic        rst, we, re, vsync;
    logic [2:0]  addr;
    logic [15:0] wdata, rdata, p1, p2, p3, p4;
    logic [7:0]  value;
    logic        rvalid, commit_done;

    always #5 clk = ~clk;

    vga_reg_bank #(
        .DATA_W(16), .VAL_W(8), .VSYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .vsync(vsync), .value(value),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .commit_done(commit_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (register-map view) ----------------
    logic [15:0] m_stg [5];
    logic [15:0] m_live[5];
    logic [15:0] m_rdata, m_frame;
    bit          m_pend, m_prev, m_start, m_cd, m_rvalid;
    bit          chk_en = 1'b0;
    bit          t_act, t_start_now, t_copy;

    function automatic logic [15:0] m_read(input logic [2:0] a, input bit act);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: return m_stg[a];
            3'd6: return {14'd0, act, m_pend};
`ifdef VGA_FRAME_CNT_EN
            3'd7: return m_frame;
`endif
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                m_stg[i]  = 16'd0;
                m_live[i] = 16'd0;
            end
            m_rdata = 16'd0; m_frame = 16'd0;
            m_pend = 1'b0; m_prev = 1'b0; m_start = 1'b0; m_cd = 1'b0; m_rvalid = 1'b0;
        end else begin
            t_act       = !vsync;
            t_start_now = m_start;
            t_copy      = t_start_now && m_pend;
            if (re) m_rdata = m_read(addr, t_act);
            m_rvalid = re;
            if (t_copy) for (int i = 0; i < 5; i++) m_live[i] = m_stg[i];
            if (we && addr == 3'd0) m_stg[0] = {8'h00, wdata[7:0]};
            else if (we && addr <= 3'd4) m_stg[addr] = wdata;
            if (we && addr == 3'd5) m_pend = 1'b1;
            else if (t_copy) m_pend = 1'b0;
            if (we && addr == 3'd7) m_frame = 16'd0;
            else if (t_start_now) m_frame = m_frame + 16'd1;
            // a vsync start becomes visible the cycle after vsync is sampled active
            m_start = t_act && !m_prev;
            m_prev  = t_act;
            m_cd    = m_start && m_pend;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_value", value, m_live[0]);
            chk("m_p1", p1, m_live[1]);
            chk("m_p2", p2, m_live[2]);
            chk("m_p3", p3, m_live[3]);
            chk("m_p4", p4, m_live[4]);
            chk("m_commit_done", commit_done, m_cd);
            chk("m_rvalid", rvalid, m_rvalid);
            if (m_rvalid) chk("m_rdata", rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        chk({nm, "_rvalid"}, rvalid, 1'b1);
        chk(nm, rdata, exp);
    endtask

    task automatic vs_pulse();
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 16'd0; vsync = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 16'd0);
        chk("rst_p1", p1, 16'd0);
        chk("rst_commit_done", commit_done, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // reset contents read back as zero
        for (int a = 1; a <= 4; a++) rd(a[2:0], 16'd0, "rst_rd_p");
        rd(3'd0, 16'd0, "rst_rd_value");

        // staging writes without COMMIT never reach live
        wr(3'd1, 16'h1234);
        wr(3'd0, 16'h12A5);
        vsync = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_commit_cd", commit_done, 1'b0);
        end
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_commit_p1", p1, 16'h0000);
        chk("no_commit_value", value, 8'h00);
        rd(3'd1, 16'h1234, "stg_p1");
        rd(3'd0, 16'h00A5, "stg_value");

        // COMMIT then vsync: pulse one cycle after the edge, live the next
        wr(3'd2, 16'hBEEF);
        wr(3'd5, 16'h0000);
        rd(3'd6, 16'h0001, "status_armed");
        vsync = 1'b0;
        @(negedge clk);
        chk("commit_cd_hi", commit_done, 1'b1);
        chk("commit_p2_old", p2, 16'h0000);
        @(negedge clk);
        chk("commit_cd_lo", commit_done, 1'b0);
        chk("commit_p2_new", p2, 16'hBEEF);
        chk("commit_p1_new", p1, 16'h1234);
        chk("commit_value_new", value, 8'hA5);
        rd(3'd6, 16'h0002, "status_idle_vs");
        vsync = 1'b1;
        repeat (2) @(negedge clk);

        // COMMIT exactly on the vsync-start cycle while IDLE: no copy this frame
        wr(3'd3, 16'h0055);
        vsync = 1'b0;
        @(negedge clk);
        chk("idle_start_cd", commit_done, 1'b0);
        wr(3'd5, 16'h0001);
        chk("idle_start_p3", p3, 16'h0000);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        chk("next_frame_cd", commit_done, 1'b1);
        @(negedge clk);
        chk("next_frame_p3", p3, 16'h0055);
        vsync = 1'b1;
        repeat (2) @(negedge clk);

        // staging write on the copy cycle: live takes the old staging value
        wr(3'd3, 16'h00FF);
        wr(3'd5, 16'h0000);
        vsync = 1'b0;
        @(negedge clk);
        wr(3'd3, 16'h0001);
        chk("copy_cycle_p3", p3, 16'h00FF);
        rd(3'd3, 16'h0001, "copy_cycle_stg_p3");
        vsync = 1'b1;
        repeat (2) @(negedge clk);

        // same-cycle write and read of one address returns the old value
        wr(3'd4, 16'h1111);
        we = 1'b1; re = 1'b1; addr = 3'd4; wdata = 16'h2222;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        chk("rw_same_old", rdata, 16'h1111);
        rd(3'd4, 16'h2222, "rw_same_new");

        // read-only addresses ignore writes
        wr(3'd6, 16'hFFFF);
        rd(3'd6, 16'h0000, "status_ro");
        rd(3'd5, 16'h0000, "commit_rd0");

        // frame counter
        wr(3'd7, 16'h0000);
        repeat (3) vs_pulse();
`ifdef VGA_FRAME_CNT_EN
        rd(3'd7, 16'd3, "frame_3");
`else
        rd(3'd7, 16'd0, "frame_absent");
`endif
        wr(3'd7, 16'h1234);
        rd(3'd7, 16'd0, "frame_clr");

        // asynchronous reset while ARMED clears live outputs immediately
        wr(3'd2, 16'h7777);
        wr(3'd5, 16'h0000);
        vs_pulse();
        chk("pre_rst_p2", p2, 16'h7777);
        wr(3'd5, 16'h0000);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_p2", p2, 16'h0000);
        chk("async_rst_value", value, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(3'd6, 16'h0000, "post_rst_status");
        rd(3'd2, 16'h0000, "post_rst_stg_p2");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_vga_reg_bank
